// File: rtl/pmu_event_shaper.sv
// rtl/pmu_event_shaper.sv - per-lane synchronise, qualify and prescale of SoC events for the PMU
// Optional EVENT_SYNC_EN: SYNC_STAGES-deep input synchroniser; undefined, events_i is taken as synchronous.
module pmu_event_shaper #(
    parameter int N_SOC_EV    = 32,
    parameter int SYNC_STAGES = 2,
    parameter int PW          = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   clear_i,
    input  logic [N_SOC_EV-1:0]    events_i,
    input  logic [2*N_SOC_EV-1:0]  mode_i,
    input  logic [N_SOC_EV*PW-1:0] div_i,
    output logic [N_SOC_EV-1:0]    events_o
);

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_LEVEL = 2'b01;
    localparam logic [1:0] MODE_RISE  = 2'b10;
    localparam logic [1:0] MODE_FALL  = 2'b11;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("pmu_event_shaper: SYNC_STAGES must be at least 2");
    end

    logic [N_SOC_EV-1:0] s;
    logic [N_SOC_EV-1:0] prev;
    logic [N_SOC_EV-1:0] q;
    logic [N_SOC_EV-1:0][PW-1:0] cnt;

`ifdef EVENT_SYNC_EN
    logic [SYNC_STAGES-1:0][N_SOC_EV-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], events_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];
`else
    assign s = events_i;
`endif

    // prev tracks s unconditionally so re-enable or a mode change never sees a stale edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev <= '0;
        end else begin
            prev <= s;
        end
    end

    always_comb begin
        q = '0;
        for (int i = 0; i < N_SOC_EV; i++) begin
            case (mode_i[2*i +: 2])
                MODE_OFF:   q[i] = 1'b0;
                MODE_LEVEL: q[i] = s[i];
                MODE_RISE:  q[i] = s[i] & ~prev[i];
                MODE_FALL:  q[i] = ~s[i] & prev[i];
                default:    q[i] = 1'b0;
            endcase
        end
    end

    // >= rather than == so lowering div below a running count fires on the next event
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt      <= '0;
            events_o <= '0;
        end else begin
            for (int i = 0; i < N_SOC_EV; i++) begin
                if (!enable_i || clear_i) begin
                    cnt[i]      <= '0;
                    events_o[i] <= 1'b0;
                end else if (q[i] && (cnt[i] >= div_i[PW*i +: PW])) begin
                    cnt[i]      <= '0;
                    events_o[i] <= 1'b1;
                end else if (q[i]) begin
                    cnt[i]      <= cnt[i] + 1'b1;
                    events_o[i] <= 1'b0;
                end else begin
                    events_o[i] <= 1'b0;
                end
            end
        end
    end

endmodule
